// File: rtl/mls_gen.sv
// Runtime-configurable maximum-length-sequence generator: one shared Fibonacci LFSR
// of width MAX_ORDER, with chip-rate divider, period flag and repetition control.
module mls_gen #(
  parameter int MAX_ORDER = 16,
  parameter int DIV_W     = 8,
  parameter int REP_W     = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [4:0]       order_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [REP_W-1:0] rep_i,
  output logic             sig_o,
  output logic             chip_o,
  output logic             flag_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0]           ORD_MIN = 5'd3;
  localparam logic [4:0]           ORD_MAX = 5'(MAX_ORDER);
  localparam logic [MAX_ORDER-1:0] ONES    = '1;

  // Feedback tap masks (bit k-1 set for 1-based tap k); orders beyond MAX_ORDER vanish.
  function automatic logic [MAX_ORDER-1:0] tap_mask(input logic [4:0] ord);
    logic [15:0] m;
    case (ord)
      5'd3:    m = 16'h0006;
      5'd4:    m = 16'h000C;
      5'd5:    m = 16'h0014;
      5'd6:    m = 16'h0030;
      5'd7:    m = 16'h0060;
      5'd8:    m = 16'h00B8;
      5'd9:    m = 16'h0110;
      5'd10:   m = 16'h0240;
      5'd11:   m = 16'h0500;
      5'd12:   m = 16'h0829;
      5'd13:   m = 16'h100D;
      5'd14:   m = 16'h2015;
      5'd15:   m = 16'h6000;
      5'd16:   m = 16'hD008;
      default: m = 16'h0000;
    endcase
    if (ord > ORD_MAX) m = 16'h0000;
    return m[MAX_ORDER-1:0];
  endfunction

  state_t               state;
  logic [MAX_ORDER-1:0] sr;
  logic [MAX_ORDER-1:0] chip_cnt;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_q;
  logic [REP_W-1:0]     rep_cnt;
  logic [REP_W-1:0]     rep_q;
  logic [4:0]           order_q;

  logic [MAX_ORDER-1:0] len_mask;
  logic [MAX_ORDER-1:0] top_mask;
  logic [MAX_ORDER-1:0] seed;
  logic [MAX_ORDER-1:0] sr_adv;
  logic [MAX_ORDER-1:0] sr_nx;
  logic [MAX_ORDER-1:0] chip_nx;
  logic [DIV_W-1:0]     div_nx;
  logic                 order_ok;
  logic                 last_clk;
  logic                 fb;
  logic                 wrap;
  logic                 finish;

  assign len_mask = ~(ONES << order_q);
  assign top_mask = len_mask ^ (len_mask >> 1);
  assign seed     = ~(ONES << order_i);
  assign order_ok = (order_i >= ORD_MIN) && (order_i <= ORD_MAX);

  // Values the counters and register take after this clock, so outputs can be registered from them.
  assign last_clk = (div_cnt == div_q);
  assign fb       = ^(sr & tap_mask(order_q));
  assign sr_adv   = {sr[MAX_ORDER-2:0], fb} & len_mask;
  assign wrap     = last_clk && (chip_cnt == (len_mask - 1'b1));
  assign finish   = wrap && (rep_q != '0) && ((rep_cnt + 1'b1) == rep_q);
  assign sr_nx    = last_clk ? sr_adv : sr;
  assign chip_nx  = !last_clk ? chip_cnt : (wrap ? '0 : chip_cnt + 1'b1);
  assign div_nx   = last_clk ? '0 : div_cnt + 1'b1;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      sr       <= '0;
      chip_cnt <= '0;
      div_cnt  <= '0;
      rep_cnt  <= '0;
      div_q    <= '0;
      rep_q    <= '0;
      order_q  <= '0;
      sig_o    <= 1'b0;
      chip_o   <= 1'b0;
      flag_o   <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            if (order_ok) begin
              order_q  <= order_i;
              div_q    <= div_i;
              rep_q    <= rep_i;
              sr       <= seed;
              div_cnt  <= '0;
              chip_cnt <= '0;
              rep_cnt  <= '0;
              state    <= RUN;
              busy_o   <= 1'b1;
              chip_o   <= 1'b1;
              flag_o   <= 1'b1;
              sig_o    <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          // An abort on the final wrap still wins over completion.
          if (stop_i || finish) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            chip_o <= 1'b0;
            flag_o <= 1'b0;
            sig_o  <= 1'b0;
            done_o <= !stop_i;
          end else begin
            sr       <= sr_nx;
            div_cnt  <= div_nx;
            chip_cnt <= chip_nx;
            if (wrap) rep_cnt <= rep_cnt + 1'b1;
            busy_o   <= 1'b1;
            chip_o   <= last_clk;
            flag_o   <= (chip_nx == '0);
            sig_o    <= |(sr_nx & top_mask);
          end
        end
      endcase
    end
  end

endmodule
